// File: rtl/regfile_write_arbiter_if.sv
// Register-file write-port bus: four requester lanes in, one registered write toward the register file out.
// Grant is combinational back to the requesters; the write fields are registered by the arbiter.
interface regfile_write_arbiter_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 64
);
    logic [3:0]          req;
    logic [4*ADDR_W-1:0] req_addr;
    logic [4*DATA_W-1:0] req_data;
    logic                wr_stall;
    logic [3:0]          gnt;
    logic                RegWrite;
    logic [ADDR_W-1:0]   WriteRegister;
    logic [DATA_W-1:0]   WriteData;
    logic [1:0]          grant_idx;

    modport master (
        output req, req_addr, req_data, wr_stall,
        input  gnt, RegWrite, WriteRegister, WriteData, grant_idx
    );

    modport slave (
        input  req, req_addr, req_data, wr_stall,
        output gnt, RegWrite, WriteRegister, WriteData, grant_idx
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter for the single register-file write port; the write strobe appears 1 cycle after acceptance.
// wr_stall or reset low forces gnt to zero in the same cycle; no request is consumed while stalled.
module regfile_write_arbiter #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    regfile_write_arbiter_if.slave bus
);
    localparam logic [ADDR_W-1:0] XZR = '1;

    logic [1:0]        ptr;
    logic [1:0]        sel;
    logic              xfer;
    logic [ADDR_W-1:0] addr_arr [4];
    logic [DATA_W-1:0] data_arr [4];

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            addr_arr[i] = bus.req_addr[i*ADDR_W +: ADDR_W];
            data_arr[i] = bus.req_data[i*DATA_W +: DATA_W];
        end
    end

    // Scan from the farthest slot back to ptr so the closest requesting slot wins.
    always_comb begin
        sel = ptr;
        for (int k = 3; k >= 0; k--) begin
            if (bus.req[ptr + 2'(k)]) begin
                sel = ptr + 2'(k);
            end
        end
    end

    assign xfer    = reset && !bus.wr_stall && (|bus.req);
    assign bus.gnt = xfer ? (4'b0001 << sel) : 4'b0000;

    always_ff @(posedge clk) begin
        if (!reset) begin
            ptr               <= '0;
            bus.RegWrite      <= 1'b0;
            bus.WriteRegister <= '0;
            bus.WriteData     <= '0;
            bus.grant_idx     <= '0;
        end else if (xfer) begin
            // A write to XZR is consumed and granted but must not strobe the register file.
            bus.RegWrite      <= (addr_arr[sel] != XZR);
            bus.WriteRegister <= addr_arr[sel];
            bus.WriteData     <= data_arr[sel];
            bus.grant_idx     <= sel;
            ptr               <= sel + 2'd1;
        end else begin
            bus.RegWrite      <= 1'b0;
        end
    end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: table-driven cycle vectors plus hand sequences, outputs checked through a scoreboard queue.
module tb_regfile_write_arbiter;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    regfile_write_arbiter_if #(.ADDR_W(5), .DATA_W(64)) bus ();

    regfile_write_arbiter #(.ADDR_W(5), .DATA_W(64)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic        rw;
        logic [4:0]  wr;
        logic [63:0] wd;
        logic [1:0]  idx;
    } out_t;

    typedef struct {
        logic       r;
        logic [3:0] rq;
        logic       st;
        logic [3:0] eg;
        out_t       eo;
    } vec_t;

    out_t sb [$];
    vec_t tbl [15];
    int tests = 0;
    int fails = 0;

    function automatic logic [63:0] dval(input int i);
        return 64'hCAFE_0000_0000_0000 | 64'(i);
    endfunction

    function automatic vec_t mk(input logic r, input logic [3:0] rq, input logic st, input logic [3:0] eg,
                                input logic rw, input logic [4:0] wr, input logic [63:0] wd, input logic [1:0] idx);
        vec_t v;
        v.r = r; v.rq = rq; v.st = st; v.eg = eg;
        v.eo.rw = rw; v.eo.wr = wr; v.eo.wd = wd; v.eo.idx = idx;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h want %0h", nm, got, exp);
        end
    endtask

    task automatic set_lane(input int i, input logic [4:0] a, input logic [63:0] d);
        bus.req_addr[i*5 +: 5]  = a;
        bus.req_data[i*64 +: 64] = d;
    endtask

    // One cycle: drive, check combinational grant, push expected registered result, check it after the edge.
    task automatic apply(input string nm, input vec_t v);
        out_t e;
        @(negedge clk);
        reset        = v.r;
        bus.req      = v.rq;
        bus.wr_stall = v.st;
        #1;
        chk({nm, " gnt"}, 64'(bus.gnt), 64'(v.eg));
        sb.push_back(v.eo);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL %s scoreboard: got empty want entry", nm);
        end else begin
            e = sb.pop_front();
            chk({nm, " RegWrite"},      64'(bus.RegWrite),      64'(e.rw));
            chk({nm, " WriteRegister"}, 64'(bus.WriteRegister), 64'(e.wr));
            chk({nm, " WriteData"},     bus.WriteData,          e.wd);
            chk({nm, " grant_idx"},     64'(bus.grant_idx),     64'(e.idx));
        end
    endtask

    initial begin
        reset        = 1'b0;
        bus.req      = 4'b1111;
        bus.wr_stall = 1'b0;
        bus.req_addr = '0;
        bus.req_data = '0;
        for (int i = 0; i < 4; i++) set_lane(i, 5'(3 + 4*i), dval(i));

        // reset hold, round-robin, stall, idle, reset mid-stream at ptr=3
        tbl[0]  = mk(0, 4'b1111, 0, 4'b0000, 0, 0,  0,       0);
        tbl[1]  = mk(0, 4'b1111, 0, 4'b0000, 0, 0,  0,       0);
        tbl[2]  = mk(1, 4'b1111, 0, 4'b0001, 1, 3,  dval(0), 0);
        tbl[3]  = mk(1, 4'b1111, 0, 4'b0010, 1, 7,  dval(1), 1);
        tbl[4]  = mk(1, 4'b1111, 0, 4'b0100, 1, 11, dval(2), 2);
        tbl[5]  = mk(1, 4'b1111, 0, 4'b1000, 1, 15, dval(3), 3);
        tbl[6]  = mk(1, 4'b1111, 0, 4'b0001, 1, 3,  dval(0), 0);
        tbl[7]  = mk(1, 4'b1111, 0, 4'b0010, 1, 7,  dval(1), 1);
        tbl[8]  = mk(1, 4'b1111, 1, 4'b0000, 0, 7,  dval(1), 1);
        tbl[9]  = mk(1, 4'b1111, 1, 4'b0000, 0, 7,  dval(1), 1);
        tbl[10] = mk(1, 4'b1111, 1, 4'b0000, 0, 7,  dval(1), 1);
        tbl[11] = mk(1, 4'b1111, 0, 4'b0100, 1, 11, dval(2), 2);
        tbl[12] = mk(1, 4'b0000, 0, 4'b0000, 0, 11, dval(2), 2);
        tbl[13] = mk(0, 4'b1111, 0, 4'b0000, 0, 0,  0,       0);
        tbl[14] = mk(1, 4'b1111, 0, 4'b0001, 1, 3,  dval(0), 0);

        for (int i = 0; i < 15; i++) apply($sformatf("vec%0d", i), tbl[i]);

        // Pointer skip: ptr=1, only requester 2 asks; then ptr must be 3.
        set_lane(2, 5'd9, 64'hDEAD_BEEF);
        apply("skip", mk(1, 4'b0100, 0, 4'b0100, 1, 9, 64'hDEAD_BEEF, 2));
        set_lane(2, 5'd11, dval(2));
        apply("skip_ptr", mk(1, 4'b1111, 0, 4'b1000, 1, 15, dval(3), 3));

        // XZR write: granted and consumed, but no strobe; ptr advances to 1.
        set_lane(0, 5'd31, dval(0));
        apply("xzr", mk(1, 4'b0001, 0, 4'b0001, 0, 31, dval(0), 0));
        apply("xzr_ptr", mk(1, 4'b0011, 0, 4'b0010, 1, 7, dval(1), 1));

        // Reset dominates stall.
        apply("rst_stall", mk(0, 4'b1111, 1, 4'b0000, 0, 0, 0, 0));
        // Stall dominates req, right after reset release.
        apply("stall_req", mk(1, 4'b1111, 1, 4'b0000, 0, 0, 0, 0));
        apply("after", mk(1, 4'b1010, 0, 4'b0010, 1, 7, dval(1), 1));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Shares the register file's single write port among four requesters (e.g. ALU writeback, load writeback, link-register write, debug/host write) using round-robin arbitration. Each cycle it grants at most one requester and registers the winner's destination register, write data and write strobe toward the register file. Those registered outputs feed the 2-to-4 and 5-to-32 write-enable decoders and the write-data bus. The 2-bit encoded grant index is also exported for the writeback mux and for debug.

## Interface

Parameters:
- ADDR_W, 5, register address width (32 registers, X31 = XZR).
- DATA_W, 64, register data width.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low; reset asserted when 0.
- req  input  4  per-requester write request; bit i belongs to requester i.
- req_addr  input  4*ADDR_W  destination register; requester i uses bits [i*ADDR_W +: ADDR_W].
- req_data  input  4*DATA_W  write data; requester i uses bits [i*DATA_W +: DATA_W].
- wr_stall  input  1  register file cannot accept a write this cycle.
- gnt  output  4  combinational one-hot grant; at most one bit set.
- RegWrite  output  1  registered write strobe to the register file.
- WriteRegister  output  ADDR_W  registered destination address.
- WriteData  output  DATA_W  registered write data.
- grant_idx  output  2  registered encoded index of the last accepted requester.

## Operation

- State: round-robin pointer ptr[1:0], reset 0. ptr holds the highest-priority requester index.
- Selection: scan indices ptr, ptr+1, ptr+2, ptr+3 (mod 4); sel = first i with req[i]=1.
- Grant: gnt = onehot(sel) when reset=1 AND wr_stall=0 AND |req. Otherwise gnt = 4'b0000.
- Handshake: transfer for requester i occurs at a rising edge where req[i]=1 and gnt[i]=1.
  - Requester holds req_addr/req_data stable while req is high and ungranted.
  - Requester may keep req high after a transfer to request again.
- On a transfer (edge):
  - WriteRegister <= addr[sel], WriteData <= data[sel], grant_idx <= sel.
  - RegWrite <= 1, unless addr[sel] = 31 (XZR), in which case RegWrite <= 0. The request is still consumed and gnt is still given.
  - ptr <= sel+1 mod 4 (wraps 3 -> 0).
- No transfer (no req, stall): RegWrite <= 0; WriteRegister, WriteData, grant_idx and ptr hold.
- Fairness: a continuously requesting requester is granted within 4 non-stalled cycles.
- Stall: wr_stall=1 forces gnt=0 the same cycle. RegWrite is 0 the following cycle. ptr is unchanged.
- Reset (reset=0 at an edge):
  - ptr=0, RegWrite=0, WriteRegister=0, WriteData=0, grant_idx=0.
  - gnt is gated to 0 combinationally while reset=0.
  - Reset mid-stream discards any pending request. No write strobe is produced for a cycle in which reset was low.
- Simultaneous events: reset dominates stall; stall dominates req.

## Timing

- gnt: combinational from req, wr_stall, reset and ptr. No combinational path from req_addr/req_data to gnt.
- Latency: the write strobe appears 1 cycle after acceptance. Handshake at edge k → RegWrite/WriteRegister/WriteData valid during cycle k+1; the register file writes them at edge k+1.
- Throughput: one write per cycle when not stalled.
- RegWrite is high for exactly one cycle per accepted non-XZR request. It is never high two cycles for a single transfer.
- All outputs have a defined value from the first edge with reset=0. There are no X values on gnt after reset.

## Test plan

- Reset: hold reset=0 for 2 cycles with req=4'b1111 → gnt=0000, RegWrite=0, WriteRegister=0, WriteData=0, grant_idx=0. First cycle after release → gnt=0001.
- Round-robin: req=1111 held, addresses 3/7/11/15, wr_stall=0.
  - gnt sequence: 0001, 0010, 0100, 1000, 0001.
  - RegWrite=1 every cycle from the second cycle onward.
  - WriteRegister sequence: 3, 7, 11, 15.
  - grant_idx sequence: 0, 1, 2, 3.
- Pointer skip: after a grant to requester 0 (ptr=1), apply req=0100, addr2=9, data2=64'hDEAD_BEEF → gnt=0100. Next cycle: RegWrite=1, WriteRegister=9, WriteData=64'hDEAD_BEEF, grant_idx=2; ptr=3.
- Stall: req=1111, ptr=2, wr_stall=1 for 3 cycles → gnt=0000 during the stall; RegWrite=0 for those cycles plus one; ptr stays 2. On release → gnt=0100.
- XZR: req=0001, addr0=31 → gnt=0001; next cycle RegWrite=0, grant_idx=0, ptr=1. A following req=0011 → gnt=0010.
- Reset mid-stream: req=1111 streaming; drive reset=0 for one cycle while ptr=3 → gnt=0000 that cycle; RegWrite=0 the next cycle; after release → gnt=0001 (ptr=0).
